div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 108 ++++++++++
 tb/tb_div_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit restoring divider controller (DIV/DIVU) with pipeline stall/annul handshake.
// Result packs {remainder, quotient}; one quotient bit is produced per BUSY cycle.
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_div,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] DIVZERO = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] dvs_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [63:0] result_reg;

  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] partial;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  assign accept = (state_reg == IDLE) && start && !annul;

  // Magnitudes are taken at acceptance so the iterative core is purely unsigned.
  assign a_mag = (signed_div && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (signed_div && b[31]) ? (~b + 32'd1) : b;

  // The dividend shifts out of quo_reg MSB-first while quotient bits shift in at the LSB.
  assign partial  = {rem_reg, quo_reg[31]};
  assign diff     = partial - {1'b0, dvs_reg};
  assign q_bit    = ~diff[32];
  assign rem_next = q_bit ? diff[31:0] : partial[31:0];
  assign quo_next = {quo_reg[30:0], q_bit};

  assign quo_final = neg_q_reg ? (~quo_next + 32'd1) : quo_next;
  assign rem_final = neg_r_reg ? (~rem_next + 32'd1) : rem_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= 6'd0;
      rem_reg    <= 32'd0;
      quo_reg    <= 32'd0;
      dvs_reg    <= 32'd0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= 64'd0;
    end else if (annul) begin
      // Cancel wins over everything; result keeps the last completed value.
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            rem_reg   <= 32'd0;
            quo_reg   <= a_mag;
            dvs_reg   <= b_mag;
            neg_q_reg <= signed_div && (a[31] ^ b[31]);
            neg_r_reg <= signed_div && a[31];
            cnt_reg   <= 6'd0;
            state_reg <= (b == 32'd0) ? DIVZERO : BUSY;
          end
        end
        BUSY: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            state_reg  <= DONE;
            result_reg <= {rem_final, quo_final};
          end
        end
        DIVZERO: begin
          state_reg  <= DONE;
          result_reg <= 64'd0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign result = result_reg;
  assign ready  = (state_reg == DONE) && !annul;
  assign stall  = accept || (state_reg == BUSY) || (state_reg == DIVZERO);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: driver pushes expected results, a monitor pops on every ready pulse.
module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_div;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int total_checks = 0;
  int pass_checks  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  div_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .a         (a),
    .b         (b),
    .signed_div(signed_div),
    .start     (start),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) pass_checks++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {63'd0, ready}, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result", result, e);
        $display("txn: ready result=0x%016h expected=0x%016h", result, e);
      end
    end
  end

  // Waits (bounded) for ready; returns number of edges after the acceptance edge.
  task automatic wait_ready(output int n, output logic busy_stall_ok);
    n = 0;
    busy_stall_ok = 1'b1;
    while (ready !== 1'b1 && n < 100) begin
      if (stall !== 1'b1) busy_stall_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input logic [63:0] exp_res, input int exp_lat, input string name);
    int n;
    logic ok;
    @(negedge clk);
    a = av; b = bv; signed_div = s; start = 1'b1;
    #1 check({name, "_stall_on_start"}, {63'd0, stall}, 64'd1);
    exp_q.push_back(exp_res);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEADBEEF; b = 32'h0; signed_div = ~s;
    wait_ready(n, ok);
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_stall_busy"}, {63'd0, ok}, 64'd1);
    check({name, "_stall_done"}, {63'd0, stall}, 64'd0);
    last_res = exp_res;
    @(negedge clk);
    check({name, "_ready_pulse_len"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    int n;
    logic ok;
    resetn = 1'b0; a = 32'd0; b = 32'd0; signed_div = 1'b0; start = 1'b0; annul = 1'b0;
    last_res = 64'd0;
    #2;
    check("reset_result", result, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    #20 resetn = 1'b1;

    run_op(32'd7,        32'd2,        1'b0, 64'h00000001_00000003, 32, "u7div2");
    run_op(32'hFFFFFFF9, 32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFD, 32, "sm7div2");
    run_op(32'd7,        32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 32, "s7divm2");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 32, "sminovf");
    run_op(32'hFFFFFFFF, 32'd1,        1'b0, 64'h00000000_FFFFFFFF, 32, "umaxdiv1");
    run_op(32'hFFFFFFF9, 32'd2,        1'b0, 64'h00000001_7FFFFFFC, 32, "uf9div2");
    run_op(32'hFFFFFF9C, 32'd7,        1'b1, 64'hFFFFFFFE_FFFFFFF2, 32, "sm100div7");
    run_op(32'd1234,     32'd0,        1'b1, 64'h00000000_00000000, 1,  "divzero");
    run_op(32'd100,      32'd7,        1'b1, 64'h00000002_0000000E, 32, "s100div7");

    // Annul at step 10: no ready, result held, immediate restart works.
    @(negedge clk);
    a = 32'd55; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_ready", {63'd0, ready}, 64'd0);
    check("annul_idle_stall", {63'd0, stall}, 64'd0);
    check("annul_result_held", result, last_res);
    $display("txn: annul at step 10 result=0x%016h", result);
    run_op(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 32, "after_annul");

    // Asynchronous reset mid-BUSY, applied between clock edges.
    @(negedge clk);
    a = 32'd99; b = 32'd4; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_result", result, 64'd0);
    check("async_rst_ready", {63'd0, ready}, 64'd0);
    check("async_rst_stall", {63'd0, stall}, 64'd0);
    $display("txn: async reset mid-busy result=0x%016h", result);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_result", result, 64'd0);
    run_op(32'd9, 32'd4, 1'b0, 64'h00000001_00000002, 32, "post_rst");

    // Back-to-back starts held high: one ready each, one IDLE cycle in between.
    @(negedge clk);
    a = 32'd1000; b = 32'd10; signed_div = 1'b0; start = 1'b1;
    exp_q.push_back(64'h00000000_00000064);
    exp_q.push_back(64'h00000078_00123456);
    @(negedge clk);
    wait_ready(n, ok);
    check("b2b_first_latency", 64'(n), 64'd32);
    a = 32'h12345678; b = 32'h100;
    @(negedge clk);
    check("b2b_idle_ready", {63'd0, ready}, 64'd0);
    check("b2b_idle_stall", {63'd0, stall}, 64'd1);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_gap", 64'(n), 64'd33);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
